// File: rtl/pwr_seq_pkg.sv
// Shared state encoding and domain indices for the power-sequencing controller.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISO_ON,
        SAVE,
        WAIT_OFF,
        WAIT_ON,
        RESTORE,
        ISO_OFF,
        DONE
    } pwr_seq_state_e;

    localparam int unsigned DOM_IN  = 0;
    localparam int unsigned DOM_MUX = 1;
    localparam int unsigned NUM_DOM = 2;

endpackage

// File: rtl/pwr_settle_timer.sv
// Load/count-down settle timer; tc is high while the count is zero.
module pwr_settle_timer #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
    // Loading N-1 makes the wait state last exactly N cycles, tc included.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Two-domain power sequencer (isolation, retention, power switch, settle wait).
// Define PWR_SEQ_RETENTION_EN to include the SAVE/RESTORE retention steps.
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_dom,
    input  logic       req_on,
    output logic       done,
    output logic       IN_PWR,
    output logic       MUX_PWR,
    output logic [1:0] iso_en,
    output logic [1:0] ret_save,
    output logic [1:0] ret_restore
);

    pwr_seq_state_e     state;
    logic [NUM_DOM-1:0] pwr;
    logic               dom;
    logic               in_wait;
    logic               tc;

    // The timer reloads in every non-wait state, so it is primed on wait entry.
    assign in_wait = (state == WAIT_OFF) || (state == WAIT_ON);

    pwr_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (!in_wait),
        .en    (in_wait),
        .tc    (tc)
    );

    assign IN_PWR  = pwr[DOM_IN];
    assign MUX_PWR = pwr[DOM_MUX];

    // NOTE: all state and outputs update with <= so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pwr       <= '1;
            iso_en    <= '0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            dom       <= 1'b0;
`ifdef PWR_SEQ_RETENTION_EN
            ret_save    <= '0;
            ret_restore <= '0;
`endif
        end else begin
            // NOTE: strobes default low here so each is high only in its own state.
            done <= 1'b0;
`ifdef PWR_SEQ_RETENTION_EN
            ret_save    <= '0;
            ret_restore <= '0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dom       <= req_dom;
                        req_ready <= 1'b0;
                        if (req_on == pwr[req_dom]) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (req_on) begin
                            state        <= WAIT_ON;
                            pwr[req_dom] <= 1'b1;
                        end else begin
                            state           <= ISO_ON;
                            iso_en[req_dom] <= 1'b1;
                        end
                    end
                end
                ISO_ON: begin
`ifdef PWR_SEQ_RETENTION_EN
                    state         <= SAVE;
                    ret_save[dom] <= 1'b1;
`else
                    state    <= WAIT_OFF;
                    pwr[dom] <= 1'b0;
`endif
                end
`ifdef PWR_SEQ_RETENTION_EN
                SAVE: begin
                    state    <= WAIT_OFF;
                    pwr[dom] <= 1'b0;
                end
`endif
                WAIT_OFF: begin
                    if (tc) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WAIT_ON: begin
                    if (tc) begin
`ifdef PWR_SEQ_RETENTION_EN
                        state            <= RESTORE;
                        ret_restore[dom] <= 1'b1;
`else
                        state       <= ISO_OFF;
                        iso_en[dom] <= 1'b0;
`endif
                    end
                end
`ifdef PWR_SEQ_RETENTION_EN
                RESTORE: begin
                    state       <= ISO_OFF;
                    iso_en[dom] <= 1'b0;
                end
`endif
                ISO_OFF: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifndef PWR_SEQ_RETENTION_EN
    assign ret_save    = '0;
    assign ret_restore = '0;
`endif

endmodule
